prince_sbox_layer_ctrl: RTL and testbench

PRINCE_SBOX_LAYER_CTRL -- requirements
Module: prince_sbox_layer_ctrl

---
 rtl/prince_mask_pkg.sv | 20 ++
 rtl/prince_sbox_layer_ctrl_tag_pipe.sv | 26 ++
 rtl/prince_sbox_layer_ctrl.sv | 136 +++++++++++++
 tb/tb_prince_sbox_layer_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_mask_pkg.sv
// Shared types and defaults for the masked PRINCE S-box layer controller.
package prince_mask_pkg;

  localparam int SBOX_LAT_DEF = 2;
  localparam int RND_W_DEF    = 216;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } layer_state_e;

  // Tag that travels alongside a byte through the external TwoSboxes pipeline.
  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } sbox_tag_t;

endpackage

// File: rtl/prince_sbox_layer_ctrl_tag_pipe.sv
// Valid/index shift register matching the latency of the external TwoSboxes datapath.
module sbox_tag_pipe
  import prince_mask_pkg::*;
#(
  parameter int SBOX_LAT = SBOX_LAT_DEF
) (
  input  logic      clk,
  input  logic      rst_i,
  input  sbox_tag_t tag_in,
  output sbox_tag_t tag_out
);

  sbox_tag_t tag_q [SBOX_LAT];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SBOX_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < SBOX_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[SBOX_LAT-1];

endmodule

// File: rtl/prince_sbox_layer_ctrl.sv
// Streams the eight byte shares of a 64-bit state through an external TwoSboxes
// pipeline and reassembles the substituted shares as they return.
module prince_sbox_layer_ctrl
  import prince_mask_pkg::*;
#(
  parameter int SBOX_LAT = SBOX_LAT_DEF,
  parameter int RND_W    = RND_W_DEF
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start,
  input  logic [63:0]      in1,
  input  logic [63:0]      in2,
  input  logic [63:0]      in3,
  output logic             busy,
  output logic             done,
  output logic [63:0]      out1,
  output logic [63:0]      out2,
  output logic [63:0]      out3,
  input  logic [RND_W-1:0] rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [7:0]       sb_in1,
  output logic [7:0]       sb_in2,
  output logic [7:0]       sb_in3,
  output logic [RND_W-1:0] sb_r,
  input  logic [7:0]       sb_out1,
  input  logic [7:0]       sb_out2,
  input  logic [7:0]       sb_out3
);

  layer_state_e state_q;
  logic [2:0]   cnt_q;
  logic [63:0]  sh1_q, sh2_q, sh3_q;
  logic [63:0]  out1_q, out2_q, out3_q;
  logic         busy_q, done_q;
  logic         issue, issue_last, cap_last;
  logic [5:0]   byte_lsb;
  sbox_tag_t    tag_p0, tag_pn;

  // Issue stage: a byte leaves only when fresh randomness is available.
  assign issue      = (state_q == ST_ISSUE) && rnd_valid;
  assign issue_last = issue && (cnt_q == 3'd7);
  assign byte_lsb   = {cnt_q, 3'b000};

  // Bubbles drive zeros so the datapath never sees stale shares or randomness.
  assign sb_in1    = issue ? sh1_q[byte_lsb +: 8] : 8'h00;
  assign sb_in2    = issue ? sh2_q[byte_lsb +: 8] : 8'h00;
  assign sb_in3    = issue ? sh3_q[byte_lsb +: 8] : 8'h00;
  assign sb_r      = issue ? rnd : '0;
  assign rnd_ready = issue;

  always_comb begin
    tag_p0 = '0;
    if (issue) begin
      tag_p0.vld = 1'b1;
      tag_p0.idx = cnt_q;
    end
  end

  sbox_tag_pipe #(
    .SBOX_LAT (SBOX_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_i   (rst_i),
    .tag_in  (tag_p0),
    .tag_out (tag_pn)
  );

  assign cap_last = tag_pn.vld && (tag_pn.idx == 3'd7);

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sh3_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sh1_q   <= in1;
            sh2_q   <= in2;
            sh3_q   <= in3;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue_last) begin
            cnt_q   <= 3'd0;
            state_q <= ST_DRAIN;
          end else if (issue) begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (cap_last) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Capture stage: returned bytes land in the lane named by their tag.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      out1_q <= '0;
      out2_q <= '0;
      out3_q <= '0;
    end else if (tag_pn.vld) begin
      out1_q[{tag_pn.idx, 3'b000} +: 8] <= sb_out1;
      out2_q[{tag_pn.idx, 3'b000} +: 8] <= sb_out2;
      out3_q[{tag_pn.idx, 3'b000} +: 8] <= sb_out3;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out1 = out1_q;
  assign out2 = out2_q;
  assign out3 = out3_q;

endmodule

// File: tb/tb_prince_sbox_layer_ctrl.sv
// Bench for prince_sbox_layer_ctrl: three instances (SBOX_LAT 2, 1, 4) share stimulus,
// each backed by a behavioural masked TwoSboxes model.
`timescale 1ns/1ps
module tb_prince_sbox_layer_ctrl;

  localparam int RND_W = 216;
  localparam int NI    = 3;
  localparam int NCYC  = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i, start, rnd_valid;
  logic [63:0]      in1, in2, in3;
  logic [RND_W-1:0] rnd;

  logic             busy_w [NI];
  logic             done_w [NI];
  logic             rr_w   [NI];
  logic [63:0]      o1_w   [NI];
  logic [63:0]      o2_w   [NI];
  logic [63:0]      o3_w   [NI];
  logic [7:0]       si1_w  [NI];
  logic [7:0]       si2_w  [NI];
  logic [7:0]       si3_w  [NI];
  logic [7:0]       so1_w  [NI];
  logic [7:0]       so2_w  [NI];
  logic [7:0]       so3_w  [NI];
  logic [RND_W-1:0] sr_w   [NI];

  int vectors = 0;
  int miscompares = 0;

  int done_cnt [NI], done_cyc [NI];
  int busy_bad [NI], rr_bad [NI], bub_bad [NI], byte_bad [NI];
  int rnd_bad [NI], rst_bad [NI], hold_bad [NI];
  int n_issued, last_issue;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  // PRINCE inverse S-box, entry n held in nibble n.
  function automatic logic [3:0] inv4(input logic [3:0] n);
    logic [63:0] tbl;
    tbl = 64'h1CE5_046A_98DF_237B;
    return tbl[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] inv64(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 16; k++) y[4*k +: 4] = inv4(x[4*k +: 4]);
    return y;
  endfunction

  // Stand-in TwoSboxes: output shares remask the substituted byte with sb_r bits.
  function automatic logic [23:0] two_sboxes(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [RND_W-1:0] r);
    logic [7:0] x, y;
    x = a ^ b ^ c;
    y = {inv4(x[7:4]), inv4(x[3:0])};
    return {y ^ r[7:0] ^ r[15:8], r[7:0], r[15:8]};
  endfunction

  function automatic logic [RND_W-1:0] rand_rnd();
    logic [RND_W-1:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) r = {r[RND_W-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {32'($urandom()), 32'($urandom())};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic [23:0] dp [L];

    prince_sbox_layer_ctrl #(.SBOX_LAT(L), .RND_W(RND_W)) dut (
      .clk(clk), .rst_i(rst_i), .start(start),
      .in1(in1), .in2(in2), .in3(in3),
      .busy(busy_w[g]), .done(done_w[g]),
      .out1(o1_w[g]), .out2(o2_w[g]), .out3(o3_w[g]),
      .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rr_w[g]),
      .sb_in1(si1_w[g]), .sb_in2(si2_w[g]), .sb_in3(si3_w[g]), .sb_r(sr_w[g]),
      .sb_out1(so1_w[g]), .sb_out2(so2_w[g]), .sb_out3(so3_w[g])
    );

    always @(posedge clk) begin
      dp[0] <= two_sboxes(si1_w[g], si2_w[g], si3_w[g], sr_w[g]);
      for (int j = 1; j < L; j++) dp[j] <= dp[j-1];
    end

    assign so1_w[g] = dp[L-1][23:16];
    assign so2_w[g] = dp[L-1][15:8];
    assign so3_w[g] = dp[L-1][7:0];
  end

  // Drives one layer (start in cycle 0) and tallies observations against a
  // cycle-level model of issue, busy and bubble behaviour. Called at posedge+1.
  task automatic run_layer(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                           input logic [NCYC-1:0] stall, input int restart_cyc, input int rst_cyc);
    int nis, last;
    bit dead, exp_iss, exp_busy;
    logic [191:0] held [NI];
    nis = 0; last = -1; dead = 0;
    for (int i = 0; i < NI; i++) begin
      done_cnt[i] = 0; done_cyc[i] = -1; busy_bad[i] = 0; rr_bad[i] = 0; bub_bad[i] = 0;
      byte_bad[i] = 0; rnd_bad[i] = 0; rst_bad[i] = 0; hold_bad[i] = 0; held[i] = '0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      start = (cyc == 0) || (cyc == restart_cyc);
      if (cyc == 0) begin
        in1 = a; in2 = b; in3 = c;
      end else begin
        in1 = rand64(); in2 = rand64(); in3 = rand64();
      end
      rnd_valid = !stall[cyc];
      rnd       = rand_rnd();
      rst_i     = (cyc != rst_cyc);
      if (cyc == rst_cyc) dead = 1;
      exp_iss = !dead && (cyc >= 1) && (nis < 8) && rnd_valid;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        exp_busy = !dead && (cyc >= 1) && ((nis < 8) || (cyc <= last + 1 + lat_of(i)));
        if (rr_w[i] !== exp_iss) rr_bad[i]++;
        if (busy_w[i] !== exp_busy) busy_bad[i]++;
        if (exp_iss) begin
          if (sr_w[i] !== rnd) rnd_bad[i]++;
          if (si1_w[i] !== a[8*nis +: 8] || si2_w[i] !== b[8*nis +: 8] ||
              si3_w[i] !== c[8*nis +: 8]) byte_bad[i]++;
        end else if (si1_w[i] !== 8'h00 || si2_w[i] !== 8'h00 || si3_w[i] !== 8'h00 ||
                     sr_w[i] !== '0) begin
          bub_bad[i]++;
        end
        if (done_cyc[i] >= 0 && {o1_w[i], o2_w[i], o3_w[i]} !== held[i]) hold_bad[i]++;
        if (done_w[i] === 1'b1) begin
          done_cnt[i]++;
          if (done_cyc[i] < 0) begin
            done_cyc[i] = cyc;
            held[i] = {o1_w[i], o2_w[i], o3_w[i]};
          end
        end
        if (cyc == rst_cyc && (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || rr_w[i] !== 1'b0 ||
            o1_w[i] !== '0 || o2_w[i] !== '0 || o3_w[i] !== '0)) rst_bad[i]++;
      end
      @(posedge clk); #1;
      if (exp_iss) begin
        if (nis == 7) last = cyc;
        nis++;
      end
    end
    start = 1'b0;
    rst_i = 1'b1;
    n_issued = nis;
    last_issue = last;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start = 1'b0; rnd_valid = 1'b1; rnd = rand_rnd();
    in1 = rand64(); in2 = rand64(); in3 = rand64();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if ({busy_w[i], done_w[i], rr_w[i]} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_ctrl[%0d]: busy/done/rnd_ready got %b want 000", i,
                 {busy_w[i], done_w[i], rr_w[i]});
      end
      vectors++;
      if ((o1_w[i] | o2_w[i] | o3_w[i]) !== 64'h0) begin
        miscompares++;
        $display("FAIL reset_out[%0d]: got %h/%h/%h want 0", i, o1_w[i], o2_w[i], o3_w[i]);
      end
      vectors++;
      if ({si1_w[i], si2_w[i], si3_w[i]} !== 24'h0 || sr_w[i] !== '0) begin
        miscompares++;
        $display("FAIL reset_sb[%0d]: sb_in got %h want 0, sb_r nonzero=%0d", i,
                 {si1_w[i], si2_w[i], si3_w[i]}, (sr_w[i] != '0));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unmasked();
    run_layer(64'h0, 64'h0, 64'h0, '0, -1, -1);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (done_cyc[i] !== 9 + lat_of(i) || done_cnt[i] !== 1) begin
        miscompares++;
        $display("FAIL unmasked_done[%0d]: cycle %0d count %0d, want cycle %0d count 1",
                 i, done_cyc[i], done_cnt[i], 9 + lat_of(i));
      end
      vectors++;
      if ((o1_w[i] ^ o2_w[i] ^ o3_w[i]) !== 64'hBBBB_BBBB_BBBB_BBBB) begin
        miscompares++;
        $display("FAIL unmasked_result[%0d]: got %h want BBBBBBBBBBBBBBBB", i,
                 o1_w[i] ^ o2_w[i] ^ o3_w[i]);
      end
      vectors++;
      if (busy_bad[i] !== 0) begin
        miscompares++;
        $display("FAIL unmasked_busy[%0d]: %0d bad cycles, want 0", i, busy_bad[i]);
      end
    end
  endtask

  task automatic test_masked();
    logic [63:0] b, c;
    b = rand64(); c = rand64();
    run_layer(64'h0123_4567_89AB_CDEF ^ b ^ c, b, c, '0, -1, -1);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if ((o1_w[i] ^ o2_w[i] ^ o3_w[i]) !== 64'hB732_FD89_A640_5EC1) begin
        miscompares++;
        $display("FAIL masked_result[%0d]: got %h want B732FD89A6405EC1", i,
                 o1_w[i] ^ o2_w[i] ^ o3_w[i]);
      end
      vectors++;
      if (rr_bad[i] !== 0 || rnd_bad[i] !== 0 || n_issued !== 8) begin
        miscompares++;
        $display("FAIL masked_rnd[%0d]: rnd_ready bad %0d, sb_r bad %0d, issues %0d, want 0/0/8",
                 i, rr_bad[i], rnd_bad[i], n_issued);
      end
      vectors++;
      if (byte_bad[i] !== 0) begin
        miscompares++;
        $display("FAIL masked_order[%0d]: %0d wrong issued bytes, want 0", i, byte_bad[i]);
      end
      vectors++;
      if (hold_bad[i] !== 0 || done_cyc[i] !== 9 + lat_of(i)) begin
        miscompares++;
        $display("FAIL masked_hold[%0d]: hold bad %0d done cycle %0d, want 0 and %0d",
                 i, hold_bad[i], done_cyc[i], 9 + lat_of(i));
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] b, c;
    b = rand64(); c = rand64();
    run_layer(64'h0123_4567_89AB_CDEF ^ b ^ c, b, c, NCYC'(32'h18), -1, -1);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (done_cyc[i] !== 11 + lat_of(i) || done_cnt[i] !== 1) begin
        miscompares++;
        $display("FAIL stall_done[%0d]: cycle %0d count %0d, want cycle %0d count 1",
                 i, done_cyc[i], done_cnt[i], 11 + lat_of(i));
      end
      vectors++;
      if ((o1_w[i] ^ o2_w[i] ^ o3_w[i]) !== 64'hB732_FD89_A640_5EC1) begin
        miscompares++;
        $display("FAIL stall_result[%0d]: got %h want B732FD89A6405EC1", i,
                 o1_w[i] ^ o2_w[i] ^ o3_w[i]);
      end
      vectors++;
      if (bub_bad[i] !== 0 || rr_bad[i] !== 0 || byte_bad[i] !== 0) begin
        miscompares++;
        $display("FAIL stall_bubble[%0d]: bubble %0d ready %0d order %0d, want 0/0/0",
                 i, bub_bad[i], rr_bad[i], byte_bad[i]);
      end
    end
  endtask

  task automatic test_random_stall();
    for (int it = 0; it < 6; it++) begin
      logic [63:0] x, b, c;
      logic [NCYC-1:0] m;
      int cy, n, st;
      x = rand64(); b = rand64(); c = rand64();
      m = NCYC'($urandom() & $urandom() & 32'h1FFE);
      cy = 0; n = 0; st = 0;
      while (n < 8) begin
        cy++;
        if (m[cy]) st++; else n++;
      end
      run_layer(x ^ b ^ c, b, c, m, -1, -1);
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if ((o1_w[i] ^ o2_w[i] ^ o3_w[i]) !== inv64(x)) begin
          miscompares++;
          $display("FAIL rstall_result[%0d]: got %h want %h", i, o1_w[i] ^ o2_w[i] ^ o3_w[i],
                   inv64(x));
        end
        vectors++;
        if (done_cyc[i] !== 9 + lat_of(i) + st || done_cnt[i] !== 1) begin
          miscompares++;
          $display("FAIL rstall_done[%0d]: cycle %0d count %0d, want cycle %0d count 1",
                   i, done_cyc[i], done_cnt[i], 9 + lat_of(i) + st);
        end
        vectors++;
        if (bub_bad[i] + rr_bad[i] + byte_bad[i] + rnd_bad[i] + busy_bad[i] !== 0) begin
          miscompares++;
          $display("FAIL rstall_flow[%0d]: bub %0d rr %0d byte %0d rnd %0d busy %0d, want 0",
                   i, bub_bad[i], rr_bad[i], byte_bad[i], rnd_bad[i], busy_bad[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] x, b, c;
    x = rand64(); b = rand64(); c = rand64();
    run_layer(x ^ b ^ c, b, c, '0, -1, 6);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (rst_bad[i] !== 0) begin
        miscompares++;
        $display("FAIL midrst_zero[%0d]: %0d nonzero samples in reset cycle, want 0",
                 i, rst_bad[i]);
      end
      vectors++;
      if (done_cnt[i] !== 0 || (o1_w[i] | o2_w[i] | o3_w[i]) !== 64'h0) begin
        miscompares++;
        $display("FAIL midrst_nodone[%0d]: done count %0d outs %h, want 0 and 0", i,
                 done_cnt[i], o1_w[i] | o2_w[i] | o3_w[i]);
      end
    end
    x = rand64(); b = rand64(); c = rand64();
    run_layer(x ^ b ^ c, b, c, '0, -1, -1);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if ((o1_w[i] ^ o2_w[i] ^ o3_w[i]) !== inv64(x) || done_cyc[i] !== 9 + lat_of(i)) begin
        miscompares++;
        $display("FAIL midrst_restart[%0d]: got %h at cycle %0d want %h at cycle %0d", i,
                 o1_w[i] ^ o2_w[i] ^ o3_w[i], done_cyc[i], inv64(x), 9 + lat_of(i));
      end
    end
  endtask

  task automatic test_busy_start();
    logic [63:0] x, b, c;
    x = rand64(); b = rand64(); c = rand64();
    run_layer(x ^ b ^ c, b, c, '0, 5, -1);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (done_cnt[i] !== 1) begin
        miscompares++;
        $display("FAIL busystart_count[%0d]: %0d done pulses, want 1", i, done_cnt[i]);
      end
      vectors++;
      if ((o1_w[i] ^ o2_w[i] ^ o3_w[i]) !== inv64(x)) begin
        miscompares++;
        $display("FAIL busystart_result[%0d]: got %h want %h", i,
                 o1_w[i] ^ o2_w[i] ^ o3_w[i], inv64(x));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unmasked();
    test_masked();
    test_stall();
    test_random_stall();
    test_reset_mid_run();
    test_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
